barrel_shift_pipe: RTL

//  Pipelined, parametrised barrel shifter; successor to the fixed 32-bit logical-right mux2 shifter.

---
 rtl/barrel_shift_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: SRL/SLL/SRA/ROR shifter, result NSTAGE = ceil(log2(WIDTH)/REG_EVERY) cycles after accept.
// Valid/ready on both sides, bubbles collapse, a full stalled pipe drops in_ready in the same cycle; define BSHIFT_CARRY_EN for out_carry.
module barrel_shift_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
`ifdef BSHIFT_CARRY_EN
  ,
  output logic                     out_carry
`endif
);

  localparam int LOG2W  = $clog2(WIDTH);
  localparam int NSTAGE = (LOG2W + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Index 0 is the input port, index i+1 is the register bank of stage i.
  logic [NSTAGE:0]   vs;
  logic [NSTAGE:0]   sgs;
  logic [WIDTH-1:0]  ds   [NSTAGE+1];
  logic [LOG2W-1:0]  shs  [NSTAGE+1];
  logic [1:0]        ops  [NSTAGE+1];
  logic [TAG_W-1:0]  tags [NSTAGE+1];
`ifdef BSHIFT_CARRY_EN
  logic [NSTAGE:0]   cs;
  assign cs[0] = 1'b0;
`endif
  logic [NSTAGE:0]   rdy;

  assign vs[0]   = in_valid;
  assign sgs[0]  = in_data[WIDTH-1];
  assign ds[0]   = in_data;
  assign shs[0]  = in_shamt;
  assign ops[0]  = in_op;
  assign tags[0] = in_tag;

  always_comb begin
    rdy[NSTAGE] = out_ready;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      rdy[i] = ~vs[i+1] | rdy[i+1];
    end
  end

  assign in_ready = rst_n & rdy[0];

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    localparam int LO = i * REG_EVERY;
    localparam int HI = ((i + 1) * REG_EVERY > LOG2W) ? LOG2W : (i + 1) * REG_EVERY;

    logic [WIDTH-1:0] nd;
    logic             v_q;
    logic             sg_q;
    logic [WIDTH-1:0] d_q;
    logic [LOG2W-1:0] sh_q;
    logic [1:0]       op_q;
    logic [TAG_W-1:0] tag_q;
`ifdef BSHIFT_CARRY_EN
    logic             nc;
    logic             c_q;
    logic [WIDTH-1:0] probe;
`endif

    // Carry is the last bit pushed out; for ROR that is also the new MSB.
    always_comb begin
      nd = ds[i];
`ifdef BSHIFT_CARRY_EN
      nc    = cs[i];
      probe = '0;
`endif
      for (int k = LO; k < HI; k++) begin
        if (shs[i][k]) begin
          case (ops[i])
            OP_SLL: begin
`ifdef BSHIFT_CARRY_EN
              probe = nd << ((1 << k) - 1);
              nc    = probe[WIDTH-1];
`endif
              nd = nd << (1 << k);
            end
            OP_SRA: begin
`ifdef BSHIFT_CARRY_EN
              probe = nd >> ((1 << k) - 1);
              nc    = probe[0];
`endif
              nd = (nd >> (1 << k)) | ({WIDTH{sgs[i]}} << (WIDTH - (1 << k)));
            end
            OP_ROR: begin
`ifdef BSHIFT_CARRY_EN
              probe = nd >> ((1 << k) - 1);
              nc    = probe[0];
`endif
              nd = (nd >> (1 << k)) | (nd << (WIDTH - (1 << k)));
            end
            default: begin
`ifdef BSHIFT_CARRY_EN
              probe = nd >> ((1 << k) - 1);
              nc    = probe[0];
`endif
              nd = nd >> (1 << k);
            end
          endcase
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        sg_q  <= 1'b0;
        d_q   <= '0;
        sh_q  <= '0;
        op_q  <= '0;
        tag_q <= '0;
`ifdef BSHIFT_CARRY_EN
        c_q   <= 1'b0;
`endif
      end else if (rdy[i]) begin
        v_q <= vs[i];
        if (vs[i]) begin
          sg_q  <= sgs[i];
          d_q   <= nd;
          sh_q  <= shs[i];
          op_q  <= ops[i];
          tag_q <= tags[i];
`ifdef BSHIFT_CARRY_EN
          c_q   <= nc;
`endif
        end
      end
    end

    assign vs[i+1]   = v_q;
    assign sgs[i+1]  = sg_q;
    assign ds[i+1]   = d_q;
    assign shs[i+1]  = sh_q;
    assign ops[i+1]  = op_q;
    assign tags[i+1] = tag_q;
`ifdef BSHIFT_CARRY_EN
    assign cs[i+1]   = c_q;
`endif
  end

  assign out_valid = vs[NSTAGE];
  assign out_data  = ds[NSTAGE];
  assign out_tag   = tags[NSTAGE];
`ifdef BSHIFT_CARRY_EN
  assign out_carry = cs[NSTAGE];
`endif

endmodule
